// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared memory-bus constants and copy-engine state encoding
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_t;

   localparam logic [31:0] PERIPH_BASE = 32'h0000_2000;
   localparam logic [31:0] STACK_BASE  = 32'h0000_3000;
   localparam logic [31:0] STACK_TOP   = 32'h0000_4000;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [31:0] WORD_STEP  = 32'(WORD_BYTES);

   // A byte address is usable for word transfers only when its low two bits are clear.
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-copy bus initiator sharing the data-memory port
module mem_copy_dma
   import mem_bus_pkg::*;
#(
   parameter int CNT_W     = 11,
   parameter int MAX_WORDS = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      srcAddr,
   input  logic [31:0]      dstAddr,
   input  logic [CNT_W-1:0] wordCount,
   output logic [31:0]      address,
   output logic [31:0]      writeData,
   output logic             memRead,
   output logic             memWrite,
   input  logic [31:0]      readData,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] wordsDone
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   dma_state_t       state_q, state_d;
   logic [31:0]      src_ptr_q, src_ptr_d;
   logic [31:0]      dst_ptr_q, dst_ptr_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [31:0]      data_buf_q, data_buf_d;
   logic [CNT_W-1:0] words_done_q, words_done_d;
   logic             err_q, err_d;

   // State and datapath registers; reset abandons any copy in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         src_ptr_q    <= '0;
         dst_ptr_q    <= '0;
         remaining_q  <= '0;
         data_buf_q   <= '0;
         words_done_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_ptr_q    <= src_ptr_d;
         dst_ptr_q    <= dst_ptr_d;
         remaining_q  <= remaining_d;
         data_buf_q   <= data_buf_d;
         words_done_q <= words_done_d;
         err_q        <= err_d;
      end
   end

   // Next-state and datapath update: one read then one write per word.
   always_comb begin
      state_d      = state_q;
      src_ptr_d    = src_ptr_q;
      dst_ptr_d    = dst_ptr_q;
      remaining_d  = remaining_q;
      data_buf_d   = data_buf_q;
      words_done_d = words_done_q;
      err_d        = err_q;

      unique case (state_q)
         ST_IDLE: begin
            // Abort carries no meaning here, so a coincident start always wins.
            if (start) begin
               err_d        = 1'b0;
               words_done_d = '0;
               if (!is_word_aligned(srcAddr) || !is_word_aligned(dstAddr) ||
                   (wordCount > MAX_CNT)) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (wordCount == '0) begin
                  state_d = ST_DONE;
               end else begin
                  src_ptr_d   = srcAddr;
                  dst_ptr_d   = dstAddr;
                  remaining_d = wordCount;
                  state_d     = ST_READ;
               end
            end
         end
         ST_READ: begin
            // The word is captured even when aborting; it is simply never written.
            data_buf_d = readData;
            src_ptr_d  = src_ptr_q + WORD_STEP;
            state_d    = abort ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            // The responder commits on the negedge, so this word always counts.
            dst_ptr_d    = dst_ptr_q + WORD_STEP;
            remaining_d  = remaining_q - ONE_CNT;
            words_done_d = words_done_q + ONE_CNT;
            if ((remaining_q == ONE_CNT) || abort) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus and status outputs decode from registered state only, never from inputs.
   always_comb begin
      address   = '0;
      writeData = '0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      unique case (state_q)
         ST_READ: begin
            address = src_ptr_q;
            memRead = 1'b1;
         end
         ST_WRITE: begin
            address   = dst_ptr_q;
            writeData = data_buf_q;
            memWrite  = 1'b1;
         end
         default: begin
            address = '0;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign error     = (state_q == ST_DONE) && err_q;
   assign wordsDone = words_done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - randomized self-checking bench for mem_copy_dma
module tb_mem_copy_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] srcAddr = '0;
   logic [31:0] dstAddr = '0;
   logic [10:0] wordCount = '0;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        memRead;
   logic        memWrite;
   logic [31:0] readData;
   logic        busy;
   logic        done;
   logic        error;
   logic [10:0] wordsDone;

   int checks = 0;
   int errors = 0;

   // 64 KiB responder memory; higher address bits alias onto it.
   logic [31:0] mem     [0:16383];
   logic [31:0] exp_mem [0:16383];
   logic [31:0] rd_log[$];
   logic [31:0] wr_log[$];

   mem_copy_dma #(.CNT_W(11), .MAX_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .srcAddr(srcAddr), .dstAddr(dstAddr), .wordCount(wordCount),
      .address(address), .writeData(writeData), .memRead(memRead),
      .memWrite(memWrite), .readData(readData), .busy(busy),
      .done(done), .error(error), .wordsDone(wordsDone)
   );

   always #5 clk = ~clk;

   assign readData = mem[address[15:2]];

   // Responder: log every access and commit writes on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (memRead) rd_log.push_back(address);
         if (memWrite) begin
            wr_log.push_back(address);
            mem[address[15:2]] = writeData;
         end
      end
   end

   function automatic int widx(input logic [31:0] a);
      return int'(a[15:2]);
   endfunction

   // Words written for a k-word copy given the cycle (1 = first READ) in which abort is held.
   function automatic int exp_words(input int k, input int abort_cyc);
      if (abort_cyc <= 0 || abort_cyc > 2 * k) return k;
      if (abort_cyc % 2 == 0) return abort_cyc / 2;
      return (abort_cyc - 1) / 2;
   endfunction

   function automatic int exp_reads(input int k, input int abort_cyc);
      if (abort_cyc > 0 && abort_cyc <= 2 * k && abort_cyc % 2 == 1) return exp_words(k, abort_cyc) + 1;
      return exp_words(k, abort_cyc);
   endfunction

   // Snapshot memory and apply a forward word-by-word copy of w words.
   task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int w);
      for (int i = 0; i < 16384; i++) exp_mem[i] = mem[i];
      for (int i = 0; i < w; i++)
         exp_mem[widx(d + 32'(4 * i))] = exp_mem[widx(s + 32'(4 * i))];
   endtask

   function automatic int log_mismatches(input logic [31:0] s, input logic [31:0] d,
                                         input int reads, input int writes);
      int m = 0;
      if (rd_log.size() != reads) m++;
      if (wr_log.size() != writes) m++;
      for (int i = 0; i < rd_log.size() && i < reads; i++)
         if (rd_log[i] !== s + 32'(4 * i)) m++;
      for (int i = 0; i < wr_log.size() && i < writes; i++)
         if (wr_log[i] !== d + 32'(4 * i)) m++;
      return m;
   endfunction

   function automatic int mem_mismatches();
      int m = 0;
      for (int i = 0; i < 16384; i++) if (mem[i] !== exp_mem[i]) m++;
      return m;
   endfunction

   // Issue one request and watch until done; abort/stray-start are placed by cycle after acceptance.
   task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [10:0] n,
                           input int abort_cyc, input int stray_cyc,
                           output int cyc, output logic err_o, output logic [10:0] wd_o,
                           output logic timed_out);
      rd_log.delete();
      wr_log.delete();
      @(negedge clk);
      srcAddr = s; dstAddr = d; wordCount = n; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0; timed_out = 1'b1; err_o = 1'b0; wd_o = '0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         cyc++;
         abort = (cyc == abort_cyc);
         if (cyc == stray_cyc) begin
            start = 1'b1; srcAddr = s + 32'h40; dstAddr = d + 32'h80; wordCount = 11'd1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            err_o = error; wd_o = wordsDone; timed_out = 1'b0;
            break;
         end
      end
      abort = 1'b0;
      start = 1'b0;
      if (timed_out) begin
         checks++; errors++;
         $display("FAIL timeout: done not seen within budget (src=%h n=%0d)", s, n);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({address, writeData, memRead, memWrite, busy, done, error, wordsDone} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%h wd=%h rd=%b wr=%b busy=%b done=%b err=%b wdone=%0d, want all 0",
                  address, writeData, memRead, memWrite, busy, done, error, wordsDone);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_copy();
      int cyc; logic e, to; logic [10:0] wd; int m;
      mem[widx(32'h2000)] = 32'h11; mem[widx(32'h2004)] = 32'h22;
      mem[widx(32'h2008)] = 32'h33; mem[widx(32'h200C)] = 32'h44;
      build_expect(32'h2000, 32'h2100, 4);
      run_xfer(32'h2000, 32'h2100, 11'd4, 0, 0, cyc, e, wd, to);
      checks++;
      if (cyc !== 9 || e !== 1'b0 || wd !== 11'd4) begin
         errors++;
         $display("FAIL copy_status: cyc=%0d err=%b wdone=%0d, want 9 0 4", cyc, e, wd);
      end
      m = log_mismatches(32'h2000, 32'h2100, 4, 4);
      checks++;
      if (m !== 0) begin errors++; $display("FAIL copy_bus: %0d access mismatches, want 0", m); end
      checks++;
      if (mem[widx(32'h2100)] !== 32'h11 || mem[widx(32'h210C)] !== 32'h44 || mem_mismatches() !== 0) begin
         errors++;
         $display("FAIL copy_mem: dst0=%h dst3=%h, want 11 44", mem[widx(32'h2100)], mem[widx(32'h210C)]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wordsDone !== 11'd4 || busy !== 1'b0) begin
         errors++; $display("FAIL copy_hold: wdone=%0d busy=%b, want 4 0", wordsDone, busy);
      end
   endtask

   task automatic test_rejects();
      int cyc; logic e, to; logic [10:0] wd;
      run_xfer(32'h2002, 32'h2100, 11'd3, 0, 0, cyc, e, wd, to);
      checks++;
      if (cyc !== 1 || e !== 1'b1 || wd !== 11'd0 || rd_log.size() + wr_log.size() !== 0) begin
         errors++;
         $display("FAIL misaligned_src: cyc=%0d err=%b wdone=%0d acc=%0d, want 1 1 0 0",
                  cyc, e, wd, rd_log.size() + wr_log.size());
      end
      run_xfer(32'h2000, 32'h2101, 11'd2, 0, 0, cyc, e, wd, to);
      checks++;
      if (cyc !== 1 || e !== 1'b1 || rd_log.size() + wr_log.size() !== 0) begin
         errors++; $display("FAIL misaligned_dst: cyc=%0d err=%b, want 1 1", cyc, e);
      end
      run_xfer(32'h2000, 32'h3000, 11'd1025, 0, 0, cyc, e, wd, to);
      checks++;
      if (cyc !== 1 || e !== 1'b1 || rd_log.size() + wr_log.size() !== 0) begin
         errors++; $display("FAIL oversize: cyc=%0d err=%b, want 1 1", cyc, e);
      end
      run_xfer(32'h2000, 32'h3000, 11'd0, 0, 0, cyc, e, wd, to);
      checks++;
      if (cyc !== 1 || e !== 1'b0 || wd !== 11'd0 || rd_log.size() + wr_log.size() !== 0) begin
         errors++; $display("FAIL zero_count: cyc=%0d err=%b wdone=%0d, want 1 0 0", cyc, e, wd);
      end
   endtask

   task automatic test_abort();
      int cyc; logic e, to; logic [10:0] wd; int m;
      // Abort during third WRITE (cycle 6) of an 8-word copy.
      build_expect(32'h2000, 32'h3000, exp_words(8, 6));
      run_xfer(32'h2000, 32'h3000, 11'd8, 6, 0, cyc, e, wd, to);
      m = log_mismatches(32'h2000, 32'h3000, 3, 3) + mem_mismatches();
      checks++;
      if (wd !== 11'd3 || cyc !== 7 || e !== 1'b0 || m !== 0) begin
         errors++; $display("FAIL abort_write: wdone=%0d cyc=%0d err=%b mism=%0d, want 3 7 0 0", wd, cyc, e, m);
      end
      // Abort during second READ (cycle 3).
      build_expect(32'h2040, 32'h3040, exp_words(8, 3));
      run_xfer(32'h2040, 32'h3040, 11'd8, 3, 0, cyc, e, wd, to);
      m = log_mismatches(32'h2040, 32'h3040, 2, 1) + mem_mismatches();
      checks++;
      if (wd !== 11'd1 || cyc !== 4 || m !== 0) begin
         errors++; $display("FAIL abort_read: wdone=%0d cyc=%0d mism=%0d, want 1 4 0", wd, cyc, m);
      end
   endtask

   task automatic test_start_busy();
      int cyc; logic e, to; logic [10:0] wd; int m;
      build_expect(32'h2080, 32'h3080, 5);
      run_xfer(32'h2080, 32'h3080, 11'd5, 0, 3, cyc, e, wd, to);
      m = log_mismatches(32'h2080, 32'h3080, 5, 5) + mem_mismatches();
      checks++;
      if (wd !== 11'd5 || cyc !== 11 || m !== 0) begin
         errors++; $display("FAIL start_busy: wdone=%0d cyc=%0d mism=%0d, want 5 11 0", wd, cyc, m);
      end
   endtask

   task automatic test_wrap();
      int cyc; logic e, to; logic [10:0] wd; int m;
      build_expect(32'hFFFF_FFF8, 32'h2200, 3);
      run_xfer(32'hFFFF_FFF8, 32'h2200, 11'd3, 0, 0, cyc, e, wd, to);
      m = log_mismatches(32'hFFFF_FFF8, 32'h2200, 3, 3) + mem_mismatches();
      checks++;
      if (rd_log.size() !== 3 || m !== 0 || e !== 1'b0) begin
         errors++; $display("FAIL wrap: reads=%0d mism=%0d err=%b, want 3 0 0", rd_log.size(), m, e);
      end else if (rd_log[2] !== 32'h0) begin
         errors++; $display("FAIL wrap_addr: third read %h, want 00000000", rd_log[2]);
      end
   endtask

   task automatic test_reset_midwrite();
      int cyc; logic e, to; logic [10:0] wd;
      @(negedge clk);
      srcAddr = 32'h2000; dstAddr = 32'h3200; wordCount = 11'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({address, writeData, memRead, memWrite, busy, done, error, wordsDone} !== '0) begin
         errors++;
         $display("FAIL reset_midwrite: addr=%h wd=%h rd=%b wr=%b busy=%b done=%b, want all 0",
                  address, writeData, memRead, memWrite, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      build_expect(32'h2010, 32'h3300, 2);
      run_xfer(32'h2010, 32'h3300, 11'd2, 0, 0, cyc, e, wd, to);
      checks++;
      if (cyc !== 5 || wd !== 11'd2 || mem_mismatches() !== 0) begin
         errors++; $display("FAIL after_reset: cyc=%0d wdone=%0d, want 5 2", cyc, wd);
      end
   endtask

   task automatic test_random();
      int cyc; logic e, to; logic [10:0] wd; int m, n, ab, w;
      logic [31:0] s, d;
      for (int t = 0; t < 8; t++) begin
         s = 32'h2000 + (32'($urandom_range(0, 255)) << 2);
         d = (t % 3 == 0) ? s + (32'($urandom_range(1, 6)) << 2)
                          : 32'h3000 + (32'($urandom_range(0, 255)) << 2);
         n = $urandom_range(1, 24);
         ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * n) : 0;
         w = exp_words(n, ab);
         build_expect(s, d, w);
         run_xfer(s, d, 11'(n), ab, 0, cyc, e, wd, to);
         m = log_mismatches(s, d, exp_reads(n, ab), w) + mem_mismatches();
         checks++;
         if (wd !== 11'(w) || cyc !== exp_reads(n, ab) + w + 1 || e !== 1'b0 || m !== 0) begin
            errors++;
            $display("FAIL random[%0d]: src=%h dst=%h n=%0d ab=%0d wdone=%0d cyc=%0d mism=%0d, want wdone=%0d cyc=%0d",
                     t, s, d, n, ab, wd, cyc, m, w, exp_reads(n, ab) + w + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc; logic e, to; logic [10:0] wd;
      build_expect(32'h2300, 32'h3400, 2);
      run_xfer(32'h2300, 32'h3400, 11'd2, 0, 0, cyc, e, wd, to);
      build_expect(32'h3400, 32'h2400, 2);
      run_xfer(32'h3400, 32'h2400, 11'd2, 0, 0, cyc, e, wd, to);
      checks++;
      if (cyc !== 5 || wd !== 11'd2 || mem_mismatches() !== 0 || log_mismatches(32'h3400, 32'h2400, 2, 2) !== 0) begin
         errors++; $display("FAIL back_to_back: cyc=%0d wdone=%0d, want 5 2", cyc, wd);
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = $urandom;
      test_reset();
      test_copy();
      test_rejects();
      test_abort();
      test_start_busy();
      test_wrap();
      test_reset_midwrite();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
